// File: rtl/shift_sequencer.sv
// shift_sequencer
//
// Multi-cycle shift controller for the ALU shift path. One request is
// captured per transaction. A single-position shift stage is then applied
// once per clock until the captured shift amount has been consumed. The
// finished value is published on `result` together with a one-cycle `done`.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request strobe, only honoured in IDLE
//   op       in   2      00 = SRL, 01 = SLL, 10 = SRA, 11 = SRL
//   data_in  in   WIDTH  operand, captured with start
//   shamt    in   SHW    shift amount, captured with start
//   abort    in   1      cancels an operation that is still shifting
//   busy     out  1      high whenever the sequencer is not IDLE
//   done     out  1      one-cycle completion pulse, result valid with it
//   result   out  WIDTH  last completed result, held between completions

module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_shifted;
    logic [SHW-1:0]   count;
    logic [1:0]       op_reg;
    logic             load;
    logic             step;
    logic             complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort is tested before the zero-count completion so a cancel that
    // lands on the final shift cycle suppresses done and keeps result.
    // The unused encoding falls back to IDLE through the default arm.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-position shift stage; op codes 00 and 11 both select SRL.
    always_comb begin
        work_shifted = {1'b0, work[WIDTH-1:1]};
        if (op_reg == OP_SLL) begin
            work_shifted = {work[WIDTH-2:0], 1'b0};
        end else if (op_reg == OP_SRA) begin
            work_shifted = {work[WIDTH-1], work[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            count  <= '0;
            op_reg <= '0;
            result <= '0;
        end else begin
            if (load) begin
                work   <= data_in;
                count  <= shamt;
                op_reg <= op;
            end else if (step) begin
                work  <= work_shifted;
                count <= count - SHW'(1);
            end
            if (complete) begin
                result <= work;
            end
        end
    end

    // done is simply the DONE state, so it is high exactly one cycle and
    // lines up with the edge that loaded result.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } expect_t;

    expect_t expQ[$];
    int      cycleCount = 0;
    int      checks     = 0;
    int      passes     = 0;

    shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycleCount);
        end
    endtask

    // Called at a negedge; drives one start pulse sampled at the next
    // posedge and, if a done is expected, queues the hand-computed result
    // and the edge count after which done must be visible.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] d,
                                 input logic [4:0] s, input bit expectDone,
                                 input logic [31:0] expRes);
        expect_t e;
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = s;
        if (expectDone) begin
            e.res = expRes;
            e.cyc = cycleCount + 1 + int'(s) + 1;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 32'hx;
        shamt   = 5'hx;
        op      = 2'hx;
    endtask

    // Returns at the first negedge where busy is low, bounded.
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleWithinBound", {31'b0, busy}, 32'h0);
    endtask

    // Monitor: every done pops the oldest expectation and checks value and
    // arrival edge; a done with nothing queued is itself an error.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", {31'b0, done}, 32'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("doneResult", result, e.res);
                    checkOutput("doneCycle", cycleCount, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got stuck, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busyCycles;
        int stray;

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        op      = 2'b00;
        data_in = 32'h0;
        shamt   = 5'd0;

        // Reset state and quiet idle
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", {31'b0, busy}, 32'h0);
        checkOutput("resetDone", {31'b0, done}, 32'h0);
        checkOutput("resetResult", result, 32'h0);
        rst_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done || result !== 32'h0) stray++;
        end
        checkOutput("idleStable", stray, 0);

        // SRL with busy-width measurement
        applyStimulus(2'b00, 32'h8000_00F0, 5'd4, 1'b1, 32'h0800_000F);
        busyCycles = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) busyCycles++;
        end
        checkOutput("srlBusyCycles", busyCycles, 6);

        @(negedge clk);
        applyStimulus(2'b01, 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000);
        waitIdle();
        applyStimulus(2'b01, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
        waitIdle();
        applyStimulus(2'b10, 32'hF000_0000, 5'd8, 1'b1, 32'hFFF0_0000);
        waitIdle();
        applyStimulus(2'b00, 32'hF000_0000, 5'd8, 1'b1, 32'h00F0_0000);
        waitIdle();
        applyStimulus(2'b11, 32'h8000_0000, 5'd1, 1'b1, 32'h4000_0000);
        waitIdle();

        // Start mid-SHIFT is ignored; then back-to-back in first idle cycle
        applyStimulus(2'b01, 32'h1234_5678, 5'd5, 1'b1, 32'h468A_CF00);
        repeat (2) @(negedge clk);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0);
        waitIdle();
        applyStimulus(2'b10, 32'h8000_0000, 5'd3, 1'b1, 32'hF000_0000);
        waitIdle();

        // Abort during the third SHIFT cycle of a shamt=10 operation
        applyStimulus(2'b00, 32'hAAAA_AAAA, 5'd10, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abortToIdle", {31'b0, busy}, 32'h0);
        checkOutput("abortKeepsResult", result, 32'hF000_0000);
        repeat (15) @(negedge clk);

        // Abort coincident with the zero-count cycle
        applyStimulus(2'b01, 32'h0000_00FF, 5'd2, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abortAtZeroIdle", {31'b0, busy}, 32'h0);
        checkOutput("abortAtZeroResult", result, 32'hF000_0000);
        repeat (5) @(negedge clk);

        // Abort in DONE does not cancel completion
        applyStimulus(2'b00, 32'h1357_9BDF, 5'd0, 1'b1, 32'h1357_9BDF);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        waitIdle();

        // Reset mid-SHIFT clears outputs at once and nothing resumes
        applyStimulus(2'b01, 32'h0000_0001, 5'd20, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetBusy", {31'b0, busy}, 32'h0);
        checkOutput("midResetDone", {31'b0, done}, 32'h0);
        checkOutput("midResetResult", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        busyCycles = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) busyCycles++;
        end
        checkOutput("noResumeAfterReset", busyCycles, 0);

        checkOutput("noPendingDone", expQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
